// File: rtl/axi_master_pkg.sv
// Shared widths, FSM encoding and AXI constants for the read initiator.
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ADDR_BITS 32
`define AXI_DATA_BITS 32
`define AXI_LEN_BITS  4
`define AXI_ID_BITS   4
`define AXI_SIZE_BITS 3
`endif

package axi_master_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   localparam logic [`AXI_SIZE_BITS-1:0] SIZE_WORD  = 3'b010;
   localparam logic [1:0]                BURST_INCR = 2'b01;
   localparam logic [1:0]                RESP_OKAY  = 2'b00;
endpackage

// File: rtl/axi_read_master.sv
// AXI4 read-only initiator: one outstanding INCR word burst, R beats passed
// straight through to the requester, with sticky protocol-error detection.
module axi_read_master
   import axi_master_pkg::*;
#(
   parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = 4'd0
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [`AXI_ADDR_BITS-1:0] req_addr,
   input  logic [`AXI_LEN_BITS-1:0]  req_len,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [`AXI_DATA_BITS-1:0] resp_data,
   output logic                      resp_last,
   output logic                      resp_err,
   output logic                      proto_err,
   output logic [`AXI_ID_BITS-1:0]   ARID_M,
   output logic [`AXI_ADDR_BITS-1:0] ARADDR_M,
   output logic [`AXI_LEN_BITS-1:0]  ARLEN_M,
   output logic [`AXI_SIZE_BITS-1:0] ARSIZE_M,
   output logic [1:0]                ARBURST_M,
   output logic                      ARVALID_M,
   input  logic                      ARREADY_M,
   input  logic [`AXI_ID_BITS-1:0]   RID_M,
   input  logic [`AXI_DATA_BITS-1:0] RDATA_M,
   input  logic [1:0]                RRESP_M,
   input  logic                      RLAST_M,
   input  logic                      RVALID_M,
   output logic                      RREADY_M
);

   state_t                    state_q, state_d;
   logic [`AXI_ADDR_BITS-1:0] addr_q;
   logic [`AXI_LEN_BITS-1:0]  len_q;
   logic [`AXI_LEN_BITS-1:0]  beat_ctr_q;
   logic                      arvalid_q;
   logic                      proto_q;

   logic in_data;
   logic req_hs;
   logic ar_hs;
   logic r_hs;
   logic proto_hit;
   logic unused_bits;

   assign in_data = (state_q == DATA);
   assign req_hs  = req_valid && req_ready;
   assign ar_hs   = arvalid_q && ARREADY_M;
   assign r_hs    = in_data && RVALID_M && resp_ready;

   // Short burst: RLAST with beats still owed. Long burst: more beats after the count ran out.
   assign proto_hit = r_hs && ((RID_M != MASTER_ID) ||
                               ( RLAST_M && (beat_ctr_q != '0)) ||
                               (!RLAST_M && (beat_ctr_q == '0)));

   assign unused_bits = ^{req_addr[1:0], RRESP_M[0]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_hs)          state_d = ADDR;
         ADDR:    if (ar_hs)           state_d = DATA;
         DATA:    if (r_hs && RLAST_M) state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         beat_ctr_q <= '0;
         arvalid_q  <= 1'b0;
         proto_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (req_hs) begin
            addr_q     <= {req_addr[`AXI_ADDR_BITS-1:2], 2'b00};
            len_q      <= req_len;
            beat_ctr_q <= req_len;
            arvalid_q  <= 1'b1;
         end else if (ar_hs) begin
            arvalid_q  <= 1'b0;
         end
         if (r_hs && (beat_ctr_q != '0))
            beat_ctr_q <= beat_ctr_q - 1'b1;
         if (proto_hit)
            proto_q <= 1'b1;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign ARID_M     = MASTER_ID;
   assign ARADDR_M   = addr_q;
   assign ARLEN_M    = len_q;
   assign ARSIZE_M   = SIZE_WORD;
   assign ARBURST_M  = BURST_INCR;
   assign ARVALID_M  = arvalid_q;

   // R channel is a pure pass-through while in DATA, fully gated off otherwise.
   assign RREADY_M   = in_data && resp_ready;
   assign resp_valid = in_data && RVALID_M;
   assign resp_data  = in_data ? RDATA_M : '0;
   assign resp_last  = in_data && RLAST_M;
   assign resp_err   = in_data && RRESP_M[1];
   assign proto_err  = proto_q;

endmodule
